// File: rtl/nice_fifo_pkg.sv
// rtl/nice_fifo_pkg.sv - shared sizing helpers and types for the NICE staging FIFO
//
// Contents:
//   clog2            constant ceil(log2) for deriving address widths from depths
//   nice_fifo_ptr_w  pointer width for a given address width (one extra wrap bit)
//   NICE_FIFO_AW     default address width (depth 16)
//   nice_fifo_cnt_t  occupancy / pointer type at the default address width

package nice_fifo_pkg;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Pointers carry one bit beyond the address so full and empty stay distinct.
    function automatic int nice_fifo_ptr_w(input int aw);
        return aw + 1;
    endfunction

    localparam int NICE_FIFO_AW    = 4;
    localparam int NICE_FIFO_PTR_W = NICE_FIFO_AW + 1;

    typedef logic [NICE_FIFO_PTR_W-1:0] nice_fifo_cnt_t;

endpackage

// File: rtl/nice_fifo_ram.sv
// rtl/nice_fifo_ram.sv - DEPTH x DW storage, synchronous write, asynchronous read
//
// Ports:
//   clk    in   clock for the write port
//   we     in   write enable
//   waddr  in   write address
//   wdata  in   write data
//   raddr  in   read address
//   rdata  out  read data, combinational from raddr
//
// Contents are not reset; the FIFO pointers decide which entries are valid.

module nice_fifo_ram
    import nice_fifo_pkg::*;
#(
    parameter int DW    = 32,
    parameter int DEPTH = 16,
    localparam int AW   = clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/nice_sync_fifo.sv
// rtl/nice_sync_fifo.sv - first-word-fall-through synchronous FIFO with occupancy flags
//
// Optional feature macro: NICE_FIFO_HWM_EN (adds hwm_clr input and hwm output)
//
// Ports:
//   clk           in   clock, rising edge
//   rst           in   synchronous reset, active-high
//   hwm_clr       in   reload high-water mark with current count (NICE_FIFO_HWM_EN only)
//   hwm           out  peak occupancy since rst/hwm_clr (NICE_FIFO_HWM_EN only)
//   flush         in   discard all entries, overrides push/pop
//   wr_valid      in   producer has data
//   wr_ready      out  FIFO can accept (low while full or in reset)
//   wr_data       in   write data
//   rd_valid      out  head entry valid
//   rd_ready      in   consumer takes head
//   rd_data       out  head data, zero while rd_valid is low
//   count         out  occupancy 0..DEPTH
//   full/empty    out  occupancy at DEPTH / 0
//   almost_full   out  count >= AFULL_TH
//   almost_empty  out  count <= AEMPTY_TH

module nice_sync_fifo
    import nice_fifo_pkg::*;
#(
    parameter int DW        = 32,
    parameter int AW        = 4,
    parameter int AFULL_TH  = 12,
    parameter int AEMPTY_TH = 2
) (
    input  logic          clk,
    input  logic          rst,
`ifdef NICE_FIFO_HWM_EN
    input  logic          hwm_clr,
    output logic [AW:0]   hwm,
`endif
    input  logic          flush,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic [DW-1:0] wr_data,
    output logic          rd_valid,
    input  logic          rd_ready,
    output logic [DW-1:0] rd_data,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty,
    output logic          almost_full,
    output logic          almost_empty
);

    localparam int PW    = nice_fifo_ptr_w(AW);
    localparam int DEPTH = 1 << AW;

    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [PW-1:0] AFULL_C  = PW'(AFULL_TH);
    localparam logic [PW-1:0] AEMPTY_C = PW'(AEMPTY_TH);

    if (AFULL_TH > DEPTH) begin : g_bad_afull
        $error("nice_sync_fifo: AFULL_TH must not exceed DEPTH");
    end
    if (AEMPTY_TH >= DEPTH) begin : g_bad_aempty
        $error("nice_sync_fifo: AEMPTY_TH must be below DEPTH");
    end

    logic [PW-1:0] wp;
    logic [PW-1:0] rp;
    logic [PW-1:0] wp_nxt;
    logic [PW-1:0] rp_nxt;
    logic          push;
    logic          pop;
    logic [DW-1:0] ram_rdata;

    // Same low bits with differing wrap bits means the writer is a full lap ahead.
    assign full         = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign empty        = (wp == rp);
    assign count        = wp - rp;
    assign almost_full  = (count >= AFULL_C);
    assign almost_empty = (count <= AEMPTY_C);

    assign wr_ready = !full && !rst;
    assign rd_valid = !empty;
    assign push     = wr_valid && wr_ready;
    assign pop      = rd_valid && rd_ready;

    always_comb begin
        wp_nxt = wp;
        rp_nxt = rp;
        if (rst || flush) begin
            wp_nxt = '0;
            rp_nxt = '0;
        end else begin
            if (push) begin
                wp_nxt = wp + PTR_ONE;
            end
            if (pop) begin
                rp_nxt = rp + PTR_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        wp <= wp_nxt;
        rp <= rp_nxt;
    end

    // A flush drops the write presented in the same cycle.
    nice_fifo_ram #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (push && !flush),
        .waddr (wp[AW-1:0]),
        .wdata (wr_data),
        .raddr (rp[AW-1:0]),
        .rdata (ram_rdata)
    );

    assign rd_data = rd_valid ? ram_rdata : '0;

`ifdef NICE_FIFO_HWM_EN
    logic [PW-1:0] count_nxt;

    assign count_nxt = wp_nxt - rp_nxt;

    // Flush leaves the peak intact; only rst or hwm_clr lower it.
    always_ff @(posedge clk) begin
        if (rst) begin
            hwm <= '0;
        end else if (hwm_clr) begin
            hwm <= count;
        end else if (count_nxt > hwm) begin
            hwm <= count_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_nice_sync_fifo.sv
// tb/tb_nice_sync_fifo.sv - scoreboard bench for nice_sync_fifo

module tb_nice_sync_fifo;
    import nice_fifo_pkg::*;

    logic           clk;
    logic           rst;
    logic           flush;
    logic           wr_valid;
    logic           wr_ready;
    logic [31:0]    wr_data;
    logic           rd_valid;
    logic           rd_ready;
    logic [31:0]    rd_data;
    nice_fifo_cnt_t count;
    logic           full;
    logic           empty;
    logic           almost_full;
    logic           almost_empty;
`ifdef NICE_FIFO_HWM_EN
    logic           hwm_clr;
    nice_fifo_cnt_t hwm;
`endif

    int          checks;
    int          errors;
    logic [31:0] exp_q[$];
    int          mcount;

    nice_sync_fifo #(
        .DW        (32),
        .AW        (4),
        .AFULL_TH  (12),
        .AEMPTY_TH (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
`ifdef NICE_FIFO_HWM_EN
        .hwm_clr      (hwm_clr),
        .hwm          (hwm),
`endif
        .flush        (flush),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_data      (wr_data),
        .rd_valid     (rd_valid),
        .rd_ready     (rd_ready),
        .rd_data      (rd_data),
        .count        (count),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", tag, act, exp);
        end
    endtask

    // Called at a falling edge; applies inputs, checks state against the model,
    // then advances the model by what the rising edge should do.
    task automatic cyc(input logic wv, input logic [31:0] wd, input logic rr, input logic fl);
        logic push_ok;
        logic pop_ok;
        wr_valid = wv;
        wr_data  = wd;
        rd_ready = rr;
        flush    = fl;
        #1;
        chk("count", 64'(count), 64'(mcount));
        chk("full", 64'(full), 64'(mcount == 16));
        chk("empty", 64'(empty), 64'(mcount == 0));
        chk("almost_full", 64'(almost_full), 64'(mcount >= 12));
        chk("almost_empty", 64'(almost_empty), 64'(mcount <= 2));
        chk("rd_valid", 64'(rd_valid), 64'(mcount != 0));
        chk("wr_ready", 64'(wr_ready), 64'(mcount != 16));
        if (mcount == 0) begin
            chk("rd_data_idle", 64'(rd_data), 64'h0);
        end
        push_ok = wv && (mcount < 16);
        pop_ok  = rr && (mcount > 0);
        if (pop_ok) begin
            chk("rd_data", 64'(rd_data), 64'(exp_q[0]));
        end
        if (fl) begin
            exp_q.delete();
        end else begin
            if (pop_ok) begin
                void'(exp_q.pop_front());
            end
            if (push_ok) begin
                exp_q.push_back(wd);
            end
        end
        mcount = exp_q.size();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        flush    = 1'b0;
        wr_valid = 1'b0;
        wr_data  = '0;
        rd_ready = 1'b0;
`ifdef NICE_FIFO_HWM_EN
        hwm_clr  = 1'b0;
`endif
        #1;
        chk("wr_ready_in_rst", 64'(wr_ready), 64'h0);
        @(negedge clk);
        chk("rst_count", 64'(count), 64'h0);
        chk("rst_empty", 64'(empty), 64'h1);
        chk("rst_full", 64'(full), 64'h0);
        chk("rst_rd_valid", 64'(rd_valid), 64'h0);
        chk("rst_rd_data", 64'(rd_data), 64'h0);
        chk("rst_almost_empty", 64'(almost_empty), 64'h1);
        chk("rst_almost_full", 64'(almost_full), 64'h0);
`ifdef NICE_FIFO_HWM_EN
        chk("rst_hwm", 64'(hwm), 64'h0);
`endif
        rst = 1'b0;
        exp_q.delete();
        mcount = 0;
        #1;
        chk("wr_ready_after_rst", 64'(wr_ready), 64'h1);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        mcount = 0;
        do_reset();

        // Fill to full, then offer a 17th word that must be refused.
        for (int i = 0; i < 16; i++) cyc(1'b1, 32'h100 + 32'(i), 1'b0, 1'b0);
        cyc(1'b1, 32'hDEAD, 1'b0, 1'b0);

        // Drain in order, then idle with rd_ready high on an empty FIFO.
        for (int i = 0; i < 16; i++) cyc(1'b0, 32'h0, 1'b1, 1'b0);
        cyc(1'b0, 32'h0, 1'b1, 1'b0);

        // Hold occupancy at 5 while streaming through the pointer wrap.
        for (int i = 0; i < 5; i++) cyc(1'b1, 32'h200 + 32'(i), 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) cyc(1'b1, 32'h300 + 32'(i), 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) cyc(1'b0, 32'h0, 1'b1, 1'b0);
        cyc(1'b0, 32'h0, 1'b0, 1'b0);

        // At full, push and pop together: only the pop happens.
        for (int i = 0; i < 16; i++) cyc(1'b1, 32'h400 + 32'(i), 1'b0, 1'b0);
        cyc(1'b1, 32'hBAD0, 1'b1, 1'b0);
        cyc(1'b0, 32'h0, 1'b0, 1'b0);
        for (int i = 0; i < 15; i++) cyc(1'b0, 32'h0, 1'b1, 1'b0);
        cyc(1'b0, 32'h0, 1'b0, 1'b0);

        // Flush at count 7 with a write and a read offered in the same cycle.
        for (int i = 0; i < 7; i++) cyc(1'b1, 32'h500 + 32'(i), 1'b0, 1'b0);
        cyc(1'b1, 32'hF1F1, 1'b1, 1'b1);
        cyc(1'b0, 32'h0, 1'b0, 1'b0);
        cyc(1'b1, 32'h600, 1'b0, 1'b0);
        cyc(1'b0, 32'h0, 1'b1, 1'b0);
        cyc(1'b0, 32'h0, 1'b0, 1'b0);

        // Mixed random traffic with occasional flushes.
        for (int i = 0; i < 300; i++) begin
            cyc(1'($urandom_range(0, 3) != 0), $urandom, 1'($urandom_range(0, 2) == 0),
                1'($urandom_range(0, 49) == 0));
        end
        for (int i = 0; i < 17; i++) cyc(1'b0, 32'h0, 1'b1, 1'b0);
        cyc(1'b0, 32'h0, 1'b0, 1'b0);

`ifdef NICE_FIFO_HWM_EN
        do_reset();
        for (int i = 0; i < 9; i++) cyc(1'b1, 32'h700 + 32'(i), 1'b0, 1'b0);
        for (int i = 0; i < 9; i++) cyc(1'b0, 32'h0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b1, 32'h800 + 32'(i), 1'b0, 1'b0);
        #1;
        chk("hwm_peak", 64'(hwm), 64'd9);
        hwm_clr = 1'b1;
        cyc(1'b0, 32'h0, 1'b0, 1'b0);
        hwm_clr = 1'b0;
        #1;
        chk("hwm_clr", 64'(hwm), 64'd3);
        do_reset();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/nice_sync_fifo.md
Name: nice_sync_fifo

Overview:
- Parametrised synchronous FIFO for NICE coprocessor datapaths in the E203 core, such as operand and result staging between the core and accelerator.
- Uses valid/ready handshakes on both sides and reports full, empty, count and almost-full/almost-empty flags.
- Read side is first-word-fall-through: head data is visible combinationally while rd_valid=1.
- Supports power-of-two depths only, through a wrap-bit pointer scheme.

Parameters:
- DW, 32: data width in bits.
- AW, 4: address width; DEPTH = 2**AW (default 16).
- AFULL_TH, 12: almost_full asserts when count >= AFULL_TH.
- AEMPTY_TH, 2: almost_empty asserts when count <= AEMPTY_TH.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- flush  in  1  synchronous discard of all entries.
- wr_valid  in  1  producer has data.
- wr_ready  out  1  FIFO can accept; equals !full && !rst.
- wr_data  in  DW  write data.
- rd_valid  out  1  head entry valid; equals !empty.
- rd_ready  in  1  consumer takes head.
- rd_data  out  DW  head data; 0 when rd_valid=0.
- count  out  AW+1  occupancy, 0..DEPTH.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count >= AFULL_TH.
- almost_empty  out  1  count <= AEMPTY_TH.

Behaviour:
- Reset is rst, synchronous, active-high; clock is clk.
- State: wp and rp are AW+1 bits wide; the MSB is the wrap bit. The memory array is not reset.
- Reset and flush both set wp = rp = 0. Outputs after reset: count=0, empty=1, full=0, rd_valid=0, rd_data=0, almost_empty=1, almost_full=0. wr_ready=0 during the rst cycle and 1 afterwards.
- push = wr_valid && wr_ready. On a push, mem[wp[AW-1:0]] <= wr_data and wp <= wp+1. The increment wraps naturally at 2*DEPTH, so the low bits wrap at DEPTH.
- pop = rd_valid && rd_ready. On a pop, rp <= rp+1.
- Flags:
  - full: wp[AW] != rp[AW] && wp[AW-1:0] == rp[AW-1:0].
  - empty: wp == rp.
  - count: wp - rp, modulo 2**(AW+1).
- Latency: data pushed in cycle N appears on rd_data with rd_valid=1 in cycle N+1. There is no same-cycle bypass when empty.
- Simultaneous push and pop when neither full nor empty: both pointers advance and count is unchanged.
- When full: wr_ready=0, so a push is impossible even if a pop occurs in the same cycle. After that pop, wr_ready=1 in the next cycle.
- When empty: rd_valid=0, and rd_ready is ignored.
- Flush priority: flush overrides any push or pop in the same cycle. Data presented with wr_valid that cycle is dropped.
- rst has priority over flush.
- All flags are combinational from the registered pointers. They are glitch-free relative to clk only.
- Threshold rules: require AFULL_TH <= DEPTH and AEMPTY_TH < DEPTH. Violating these is a generate-time error via $error.

Optional Feature:
- Macro: NICE_FIFO_HWM_EN.
- When defined:
  - Adds output hwm [AW:0], a high-water mark holding the maximum count seen since the last rst or hwm_clr.
  - Adds input hwm_clr [1], which synchronously sets hwm <= count.
  - Updates every cycle as hwm <= max(hwm, next count).
  - flush does not clear hwm.
- When undefined: hwm and hwm_clr are absent from the port list, and no hwm logic or registers exist.

Decomposition:
- Package nice_fifo_pkg holds:
  - function clog2;
  - localparam templates for the pointer width (AW+1);
  - a typedef for the count type.
- Sub-module nice_fifo_ram: a DEPTH x DW two-port array with a synchronous write port and a combinational asynchronous read port, so it can later be swapped for a vendor RAM.

Test Plan:
1. Reset, then push 16 words 0x100..0x10F with rd_ready=0 -> full=1, wr_ready=0, count=16, almost_full set once count reaches 12. A 17th wr_valid is not accepted.
2. From full, pop 16 with rd_ready=1 -> rd_data sequence 0x100..0x10F in order, then empty=1, rd_valid=0, rd_data=0.
3. Continuous push and pop for 40 cycles at count=5 (pointer wrap past 15) -> count stays 5, and data order is preserved across the wrap.
4. At full, assert rd_ready and wr_valid together -> pop occurs, push is rejected, count=15; wr_ready=1 in the next cycle.
5. Assert flush at count=7 with wr_valid=1 -> next cycle count=0, empty=1; the flush-cycle write is absent.
6. With NICE_FIFO_HWM_EN: push 9, pop 9, push 3 -> hwm=9. Then hwm_clr -> hwm=3. Then rst -> hwm=0.
